des_cmd_router: RTL and testbench

//  Command-byte router between the UART receiver and the 8-to-64 block assembler.
//  - Parses the received byte stream into KEY frames and DATA frames.
//  - KEY frame: the 64-bit DES key is shadow-assembled, then committed atomically to key_out.
//  - DATA frame: payload bytes are forwarded unchanged to the block assembler.
//  - Replaces the constant-zero key with a key loaded over the serial link.

---
 rtl/des_link_pkg.sv | 18 +
 rtl/des_cmd_router.sv | 122 ++++++++++++
 tb/tb_des_cmd_router.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/des_link_pkg.sv
// rtl/des_link_pkg.sv - shared types, header constants and parity helper for the DES serial link
package des_link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEY_RX  = 2'd1,
    DATA_RX = 2'd2
  } state_t;

  localparam logic [7:0] KEY_CMD_DEF  = 8'hA5;
  localparam logic [7:0] DATA_CMD_DEF = 8'h5A;

  // High when the byte holds an odd number of ones (DES key-byte convention).
  function automatic logic odd_parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/des_cmd_router.sv
// rtl/des_cmd_router.sv - splits the UART byte stream into KEY and DATA frames; optional macro KEY_PARITY_CHECK_EN
module des_cmd_router
  import des_link_pkg::*;
#(
  parameter logic [7:0]  KEY_CMD     = KEY_CMD_DEF,
  parameter logic [7:0]  DATA_CMD    = DATA_CMD_DEF,
  parameter int          FRAME_BYTES = 8,
  parameter logic [63:0] RESET_KEY   = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  byte_in,
  output logic [7:0]  data_byte_out,
  output logic        data_byte_valid,
  output logic [63:0] key_out,
  output logic        key_valid,
  output logic        key_loaded,
  output logic        frame_error
);

  // A single-byte frame still needs a one-bit counter to stay legal.
  localparam int               CNT_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [63:0]       r_shadow;

  logic [63:0]       w_shadow_next;
  logic              w_last_byte;
  logic              w_key_parity_ok;

  assign w_shadow_next = {r_shadow[55:0], byte_in};
  assign w_last_byte   = (r_cnt == LAST_CNT);

`ifdef KEY_PARITY_CHECK_EN
  // Every key byte of the completed shadow value must carry odd parity.
  always_comb begin
    w_key_parity_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!odd_parity8(w_shadow_next[i*8 +: 8])) begin
        w_key_parity_ok = 1'b0;
      end
    end
  end
`else
  assign w_key_parity_ok = 1'b1;
`endif

  // Frame parser: header decode, key shadow assembly with atomic commit, payload forwarding.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_shadow        <= '0;
      data_byte_out   <= '0;
      data_byte_valid <= 1'b0;
      key_out         <= RESET_KEY;
      key_valid       <= 1'b0;
      key_loaded      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle unless re-raised below.
      data_byte_valid <= 1'b0;
      key_valid       <= 1'b0;
      frame_error     <= 1'b0;

      if (rx_done) begin
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (byte_in == KEY_CMD) begin
              r_shadow <= '0;
              r_state  <= KEY_RX;
            end else if (byte_in == DATA_CMD) begin
              r_state <= DATA_RX;
            end else begin
              frame_error <= 1'b1;
            end
          end

          KEY_RX: begin
            r_shadow <= w_shadow_next;
            if (w_last_byte) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              // key_out only ever moves here, so a partial key is never visible.
              if (w_key_parity_ok) begin
                key_out    <= w_shadow_next;
                key_valid  <= 1'b1;
                key_loaded <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          DATA_RX: begin
            data_byte_out   <= byte_in;
            data_byte_valid <= 1'b1;
            if (w_last_byte) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          default: begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_des_cmd_router.sv
// tb/tb_des_cmd_router.sv - directed self-checking bench for des_cmd_router
module tb_des_cmd_router;

  logic        clock;
  logic        reset;
  logic        rx_done;
  logic [7:0]  byte_in;
  logic [7:0]  data_byte_out;
  logic        data_byte_valid;
  logic [63:0] key_out;
  logic        key_valid;
  logic        key_loaded;
  logic        frame_error;

  int n_vec;
  int n_err;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;

  des_cmd_router dut (
    .clock           (clock),
    .reset           (reset),
    .rx_done         (rx_done),
    .byte_in         (byte_in),
    .data_byte_out   (data_byte_out),
    .data_byte_valid (data_byte_valid),
    .key_out         (key_out),
    .key_valid       (key_valid),
    .key_loaded      (key_loaded),
    .frame_error     (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // At each falling edge: check outputs produced by the previous drive, then apply the next input.
  // exp_str = {data_byte_valid, key_valid, frame_error}.
  task automatic tick(input string tag, input logic v, input logic [7:0] b,
                      input logic [2:0] exp_str, input logic [7:0] exp_d,
                      input logic [63:0] exp_key, input logic exp_ld);
    logic [2:0] obs_str;
    @(negedge clock);
    obs_str = {data_byte_valid, key_valid, frame_error};
    n_vec++;
    assert (obs_str === exp_str) else begin
      n_err++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs_str, exp_str);
    end
    if (exp_str[2]) begin
      n_vec++;
      assert (data_byte_out === exp_d) else begin
        n_err++;
        $error("FAIL %s data observed=%h expected=%h", tag, data_byte_out, exp_d);
      end
    end
    n_vec++;
    assert (key_out === exp_key) else begin
      n_err++;
      $error("FAIL %s key_out observed=%h expected=%h", tag, key_out, exp_key);
    end
    n_vec++;
    assert (key_loaded === exp_ld) else begin
      n_err++;
      $error("FAIL %s key_loaded observed=%b expected=%b", tag, key_loaded, exp_ld);
    end
    rx_done = v;
    byte_in = b;
  endtask

  initial begin
    logic [7:0]  key_bytes [8];
    logic [7:0]  mix_bytes [8];
    logic [63:0] k_exp;
    logic        ld_exp;

    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    rx_done = 1'b0;
    byte_in = 8'h00;
    key_bytes = '{8'h13, 8'h34, 8'h57, 8'h79, 8'h9B, 8'hBC, 8'hDF, 8'hF1};
    mix_bytes = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h3C, 8'h81};

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state, then 100 quiet cycles.
    for (int i = 0; i < 100; i++) tick("idle", 1'b0, 8'h00, 3'b000, 8'h00, 64'h0, 1'b0);

    // KEY frame, back-to-back bytes; key_out must not move until commit.
    tick("key_hdr", 1'b1, 8'hA5, 3'b000, 8'h00, 64'h0, 1'b0);
    for (int i = 0; i < 8; i++) tick("key_byte", 1'b1, key_bytes[i], 3'b000, 8'h00, 64'h0, 1'b0);
    tick("key_commit", 1'b0, 8'h00, 3'b010, 8'h00, K1, 1'b1);
    tick("key_after", 1'b0, 8'h00, 3'b000, 8'h00, K1, 1'b1);

    // DATA frame 01..08 back-to-back; each byte appears one cycle after its rx_done.
    tick("dat_hdr", 1'b1, 8'h5A, 3'b000, 8'h00, K1, 1'b1);
    for (int i = 1; i <= 8; i++)
      tick("dat_seq", 1'b1, 8'(i), (i == 1) ? 3'b000 : 3'b100, 8'(i - 1), K1, 1'b1);
    tick("dat_last", 1'b0, 8'h00, 3'b100, 8'h08, K1, 1'b1);
    tick("dat_after", 1'b0, 8'h00, 3'b000, 8'h00, K1, 1'b1);

    // Unknown header raises frame_error once; a DATA frame with gaps still forwards AA x8.
    tick("bad_hdr", 1'b1, 8'h3C, 3'b000, 8'h00, K1, 1'b1);
    tick("bad_err", 1'b0, 8'h00, 3'b001, 8'h00, K1, 1'b1);
    tick("bad_clear", 1'b1, 8'h5A, 3'b000, 8'h00, K1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick("aa_gap", 1'b1, 8'hAA, 3'b000, 8'h00, K1, 1'b1);
      tick("aa_fwd", 1'b0, 8'h00, 3'b100, 8'hAA, K1, 1'b1);
    end
    tick("aa_after", 1'b0, 8'h00, 3'b000, 8'h00, K1, 1'b1);

    // Payload bytes equal to header codes are forwarded as data.
    tick("mix_hdr", 1'b1, 8'h5A, 3'b000, 8'h00, K1, 1'b1);
    for (int i = 0; i < 8; i++)
      tick("mix_seq", 1'b1, mix_bytes[i], (i == 0) ? 3'b000 : 3'b100,
           (i == 0) ? 8'h00 : mix_bytes[i-1], K1, 1'b1);
    tick("mix_last", 1'b0, 8'h00, 3'b100, 8'h81, K1, 1'b1);
    tick("mix_after", 1'b0, 8'h00, 3'b000, 8'h00, K1, 1'b1);

    // All-zero key: even parity in every byte.
    tick("zk_hdr", 1'b1, 8'hA5, 3'b000, 8'h00, K1, 1'b1);
    for (int i = 0; i < 8; i++) tick("zk_byte", 1'b1, 8'h00, 3'b000, 8'h00, K1, 1'b1);
`ifdef KEY_PARITY_CHECK_EN
    k_exp  = K1;
    ld_exp = 1'b1;
    tick("zk_reject", 1'b0, 8'h00, 3'b001, 8'h00, k_exp, ld_exp);
`else
    k_exp  = 64'h0;
    ld_exp = 1'b1;
    tick("zk_commit", 1'b0, 8'h00, 3'b010, 8'h00, k_exp, ld_exp);
`endif
    tick("zk_after", 1'b0, 8'h00, 3'b000, 8'h00, k_exp, ld_exp);

    // Partial key frame, then reset (with a competing rx_done), then a clean DATA frame.
    tick("pk_hdr", 1'b1, 8'hA5, 3'b000, 8'h00, k_exp, ld_exp);
    for (int i = 0; i < 4; i++) tick("pk_byte", 1'b1, key_bytes[i], 3'b000, 8'h00, k_exp, ld_exp);
    @(negedge clock);
    reset   = 1'b1;
    rx_done = 1'b1;
    byte_in = 8'h5A;
    tick("rst_state", 1'b0, 8'h00, 3'b000, 8'h00, 64'h0, 1'b0);
    reset = 1'b0;
    tick("rst_hdr", 1'b1, 8'h5A, 3'b000, 8'h00, 64'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      tick("rst_dat", 1'b1, 8'h00, (i == 0) ? 3'b000 : 3'b100, 8'h00, 64'h0, 1'b0);
    tick("rst_last", 1'b0, 8'h00, 3'b100, 8'h00, 64'h0, 1'b0);
    tick("rst_after", 1'b0, 8'h00, 3'b000, 8'h00, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
